// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA adapter write port among NUM_REQ draw engines.
// Optional off-screen clipping: define VGA_PLOT_ARBITER_CLIP_EN.
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           done,
  input  logic [NUM_REQ-1:0]           plot_in,
  input  logic [NUM_REQ*X_W-1:0]       x_in,
  input  logic [NUM_REQ*Y_W-1:0]       y_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic [15:0]                  burst_pixels
);

  localparam int IDX_W = $clog2(NUM_REQ);
`ifdef VGA_PLOT_ARBITER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                vga_plot_q;
  logic [15:0]         burst_q;

  logic [X_W-1:0]      x_arr      [NUM_REQ];
  logic [Y_W-1:0]      y_arr      [NUM_REQ];
  logic [COLOUR_W-1:0] colour_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign x_arr[gi]      = x_in[gi*X_W +: X_W];
      assign y_arr[gi]      = y_in[gi*Y_W +: Y_W];
      assign colour_arr[gi] = colour_in[gi*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  logic [IDX_W-1:0] win_idx_d;
  logic [IDX_W:0]   cand_sum;
  always_comb begin
    win_idx_d = last_q;
    cand_sum  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_sum = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ))
        cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      if (req[cand_sum[IDX_W-1:0]])
        win_idx_d = cand_sum[IDX_W-1:0];
    end
  end

  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic                off_screen_d;
  logic                fwd_plot_d;
  logic                exit_d;

  assign sel_x        = x_arr[gidx_q];
  assign sel_y        = y_arr[gidx_q];
  assign off_screen_d = (int'(sel_x) >= X_MAX) || (int'(sel_y) >= Y_MAX);
  assign fwd_plot_d   = plot_in[gidx_q] & ~(CLIP_EN & off_screen_d);
  assign exit_d       = done[gidx_q] | ~req[gidx_q];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NUM_REQ - 1);
      gidx_q       <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      burst_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          vga_plot_q <= 1'b0;
          if (|req) begin
            gidx_q  <= win_idx_d;
            grant_q <= NUM_REQ'(1) << win_idx_d;
            busy_q  <= 1'b1;
            burst_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          vga_x_q      <= sel_x;
          vga_y_q      <= sel_y;
          vga_colour_q <= colour_arr[gidx_q];
          vga_plot_q   <= fwd_plot_d;
          if (fwd_plot_d && burst_q != 16'hFFFF)
            burst_q <= burst_q + 16'd1;
          // The pixel presented alongside done/req-drop still goes out above.
          if (exit_d) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= gidx_q;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          vga_plot_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          grant_q    <= '0;
          busy_q     <= 1'b0;
          vga_plot_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_colour   = vga_colour_q;
  assign vga_plot     = vga_plot_q;
  assign burst_pixels = burst_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, bursts, round-robin, isolation, abort, clipping.
module tb_vga_plot_arbiter;
  localparam int N  = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic [N-1:0]      req, done, plot_in;
  logic [N*XW-1:0]   x_in;
  logic [N*YW-1:0]   y_in;
  logic [N*CW-1:0]   colour_in;
  logic [N-1:0]      grant;
  logic              busy;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_colour;
  logic              vga_plot;
  logic [15:0]       burst_pixels;

  int n_checks = 0;
  int n_errors = 0;

  vga_plot_arbiter dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .done(done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .burst_pixels(burst_pixels)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_px(input int e, input int x, input int y, input int c, input logic p);
    x_in[e*XW +: XW]      = XW'(x);
    y_in[e*YW +: YW]      = YW'(y);
    colour_in[e*CW +: CW] = CW'(c);
    plot_in[e]            = p;
  endtask

  task automatic wait_grant;
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin
      tick;
      n++;
    end
    check("wait_grant", {31'd0, grant != '0}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] rr_exp [4];
  logic         clip_exp [3];
  int           n;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`ifdef VGA_PLOT_ARBITER_CLIP_EN
    clip_exp = '{1'b1, 1'b0, 1'b0};
`else
    clip_exp = '{1'b1, 1'b1, 1'b1};
`endif
    Resetn = 1'b0; req = '1; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; colour_in = '0;

    // Reset held with all requests high
    tick; tick;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_burst", burst_pixels, 0);
    Resetn = 1'b1;
    tick;
    check("rst_first_grant", grant, 3'b001);
    check("rst_first_busy", busy, 1);
    req = '0;
    tick;
    check("rst_exit_grant", grant, 0);
    $display("reset: first grant engine 0");

    // Single burst from engine 1
    req = 3'b010;
    wait_grant;
    check("sb_grant", grant, 3'b010);
    check("sb_burst_clear", burst_pixels, 0);
    for (int k = 0; k < 5; k++) begin
      set_px(1, 10 + k, 20, 4, 1'b1);
      tick;
      check("sb_plot", vga_plot, 1);
      check("sb_x", vga_x, 10 + k);
      check("sb_y", vga_y, 20);
      check("sb_colour", vga_colour, 4);
    end
    plot_in[1] = 1'b0;
    done[1] = 1'b1;
    tick;
    check("sb_done_grant", grant, 0);
    check("sb_done_busy", busy, 0);
    check("sb_done_plot", vga_plot, 0);
    check("sb_burst", burst_pixels, 5);
    done = '0; req = '0;
    tick;
    check("sb_dead_grant", grant, 0);
    check("sb_dead_plot", vga_plot, 0);
    check("sb_hold_x", vga_x, 14);
    check("sb_hold_burst", burst_pixels, 5);
    $display("single burst: engine 1 pixels %0d", burst_pixels);

    // Round-robin with all three requesting, 3-cycle bursts
    Resetn = 1'b0;
    tick;
    Resetn = 1'b1;
    req = '1;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (grant == '0 && n < 20) begin
        tick;
        n++;
      end
      check("rr_grant", grant, rr_exp[b]);
      if (b > 0) check("rr_gap", n, 2);
      $display("round robin: burst %0d grant %b gap %0d", b, grant, n);
      tick;
      tick;
      done = grant;
      tick;
      check("rr_exit", grant, 0);
      done = '0;
    end
    req = '0;
    tick;

    // Isolation: engine 2 activity while engine 0 holds the port
    req = 3'b001;
    set_px(2, 99, 99, 7, 1'b0);
    wait_grant;
    check("iso_grant", grant, 3'b001);
    for (int i = 0; i < 4; i++) begin
      set_px(0, 30 + i, 40, 2, 1'b1);
      plot_in[2] = (i % 2 == 0);
      tick;
      check("iso_x", vga_x, 30 + i);
      check("iso_y", vga_y, 40);
      check("iso_plot", vga_plot, 1);
    end
    req = '0; plot_in = '0;
    tick;
    check("iso_exit_grant", grant, 0);
    check("iso_burst", burst_pixels, 4);
    $display("isolation: engine 0 pixels %0d", burst_pixels);

    // Abort by dropping req after 2 pixels
    req = 3'b001;
    wait_grant;
    set_px(0, 50, 10, 1, 1'b1);
    tick;
    set_px(0, 51, 10, 1, 1'b1);
    tick;
    plot_in = '0; req = '0;
    tick;
    check("abort_grant", grant, 0);
    check("abort_burst", burst_pixels, 2);
    check("abort_plot", vga_plot, 0);
    $display("abort: engine 0 pixels %0d", burst_pixels);

    // Single-cycle burst: done already high when the grant arrives
    req = 3'b010; done = 3'b010;
    set_px(1, 77, 33, 5, 1'b1);
    wait_grant;
    check("one_grant", grant, 3'b010);
    tick;
    check("one_exit_grant", grant, 0);
    check("one_plot", vga_plot, 1);
    check("one_x", vga_x, 77);
    check("one_burst", burst_pixels, 1);
    req = '0; done = '0; plot_in = '0;
    tick;
    $display("single-cycle burst: engine 1 pixels %0d", burst_pixels);

    // Reset asserted mid-burst
    req = 3'b001;
    wait_grant;
    set_px(0, 60, 60, 1, 1'b1);
    tick;
    check("mrst_plot_before", vga_plot, 1);
    Resetn = 1'b0;
    #1;
    check("mrst_plot", vga_plot, 0);
    check("mrst_grant", grant, 0);
    check("mrst_burst", burst_pixels, 0);
    tick;
    tick;
    check("mrst_plot_held", vga_plot, 0);
    plot_in = '0;
    Resetn = 1'b1;
    $display("mid-burst reset: outputs cleared");

    // Clipping boundaries
    wait_grant;
    check("clip_grant", grant, 3'b001);
    set_px(0, 159, 119, 3, 1'b1);
    tick;
    check("clip_plot0", vga_plot, clip_exp[0]);
    check("clip_x0", vga_x, 159);
    set_px(0, 160, 50, 3, 1'b1);
    tick;
    check("clip_plot1", vga_plot, clip_exp[1]);
    check("clip_x1", vga_x, 160);
    set_px(0, 5, 120, 3, 1'b1);
    tick;
    check("clip_plot2", vga_plot, clip_exp[2]);
    check("clip_y2", vga_y, 120);
    plot_in = '0; done[0] = 1'b1;
    tick;
`ifdef VGA_PLOT_ARBITER_CLIP_EN
    check("clip_burst", burst_pixels, 1);
`else
    check("clip_burst", burst_pixels, 3);
`endif
    check("clip_exit_grant", grant, 0);
    done = '0; req = '0;
    tick;
    $display("clip: engine 0 pixels %0d", burst_pixels);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
